// File: rtl/clock_time_ctrl_if.sv
// Signal bundle between the time-of-day mode controller and its surroundings:
// tick/button pulses and BCD counter values in, counter controls and
// display mode/blink out.
interface clock_time_ctrl_if;
    logic       tick;
    logic       mode_btn;
    logic       up_btn;
    logic       dn_btn;
    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic [7:0] hour_q;

    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       sec_dir;
    logic       min_dir;
    logic       hour_dir;
    logic       sec_load;
    logic [7:0] sec_d;
    logic [1:0] mode;
    logic [2:0] blink;

    // Stimulus / environment side
    modport master (
        output tick, mode_btn, up_btn, dn_btn, sec_q, min_q, hour_q,
        input  sec_en, min_en, hour_en, sec_dir, min_dir, hour_dir,
        input  sec_load, sec_d, mode, blink
    );

    // Controller side
    modport slave (
        input  tick, mode_btn, up_btn, dn_btn, sec_q, min_q, hour_q,
        output sec_en, min_en, hour_en, sec_dir, min_dir, hour_dir,
        output sec_load, sec_d, mode, blink
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for the BCD sec/min/hour counter chain.
// Generates run-mode carries from the 1 Hz tick, lets the user walk the set
// modes hour -> min -> sec, auto-returns to RUN after a quiet timeout, and
// drives the display blink mask.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_RUN      | clock running, tick advances sec with min/hour carries
//   S_SET_HOUR | clock frozen, up/dn step the hour counter
//   S_SET_MIN  | clock frozen, up/dn step the minute counter
//   S_SET_SEC  | clock frozen, up or dn loads zero seconds
//
// hour_q is part of the counter bundle but no decision depends on it: hour
// wrap is handled by the hour counter itself.
module clock_time_ctrl #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int TO_W          = 4
) (
    input logic              CP,
    input logic              nCLR,
    clock_time_ctrl_if.slave bus
);

    localparam logic [1:0] S_RUN      = 2'b00;
    localparam logic [1:0] S_SET_HOUR = 2'b01;
    localparam logic [1:0] S_SET_MIN  = 2'b10;
    localparam logic [1:0] S_SET_SEC  = 2'b11;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic [1:0]      state, state_nx;
    logic [TO_W-1:0] to_cnt, to_nx;
    logic            phase, phase_nx;

    logic            sec_en_nx, min_en_nx, hour_en_nx, sec_load_nx;
    logic            sec_dir_nx, min_dir_nx, hour_dir_nx;
    logic [2:0]      field, blink_nx;

    logic            sec_wrap, min_wrap, adj_any, adj_one;

    // Exact compares: a non-BCD value never produces a carry.
    assign sec_wrap = (bus.sec_q == 8'h59);
    assign min_wrap = (bus.min_q == 8'h59);
    assign adj_any  = bus.up_btn | bus.dn_btn;
    assign adj_one  = bus.up_btn ^ bus.dn_btn;

    assign bus.mode  = state;
    assign bus.sec_d = 8'h00;

    // Next-state, timeout, blink-phase and counter-control decisions.
    always_comb begin
        state_nx    = state;
        to_nx       = to_cnt;
        phase_nx    = phase;
        sec_en_nx   = 1'b0;
        min_en_nx   = 1'b0;
        hour_en_nx  = 1'b0;
        sec_load_nx = 1'b0;
        sec_dir_nx  = bus.sec_dir;
        min_dir_nx  = bus.min_dir;
        hour_dir_nx = bus.hour_dir;
        field       = 3'b000;

        // The tick is judged on the state it arrives in, so a mode press in
        // the same cycle does not swallow a running second.
        if (state == S_RUN && bus.tick) begin
            sec_en_nx   = 1'b1;
            min_en_nx   = sec_wrap;
            hour_en_nx  = sec_wrap & min_wrap;
            sec_dir_nx  = 1'b1;
            min_dir_nx  = 1'b1;
            hour_dir_nx = 1'b1;
        end

        if (bus.mode_btn) begin
            // Mode press wins over any up/dn in the same cycle.
            state_nx = state + 2'd1;
            to_nx    = '0;
            phase_nx = 1'b0;
        end else if (state == S_RUN) begin
            to_nx    = '0;
            phase_nx = 1'b0;
        end else begin
            if (bus.tick) begin
                phase_nx = ~phase;
            end

            // Any button activity restarts the quiet period, even up+dn.
            if (adj_any) begin
                to_nx = '0;
            end else if (bus.tick) begin
                if (to_cnt == TO_LAST) begin
                    state_nx = S_RUN;
                    to_nx    = '0;
                    phase_nx = 1'b0;
                end else begin
                    to_nx = to_cnt + TO_W'(1);
                end
            end

            // Guarding on the current output keeps a pulse from stretching
            // over two edges if presses arrive back to back.
            if (adj_one) begin
                case (state)
                    S_SET_HOUR: begin
                        if (!bus.hour_en) begin
                            hour_en_nx  = 1'b1;
                            hour_dir_nx = bus.up_btn;
                        end
                    end
                    S_SET_MIN: begin
                        if (!bus.min_en) begin
                            min_en_nx  = 1'b1;
                            min_dir_nx = bus.up_btn;
                        end
                    end
                    S_SET_SEC: begin
                        if (!bus.sec_load) begin
                            sec_load_nx = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        case (state_nx)
            S_SET_HOUR: field = 3'b100;
            S_SET_MIN:  field = 3'b010;
            S_SET_SEC:  field = 3'b001;
            default:    field = 3'b000;
        endcase
        blink_nx = phase_nx ? field : 3'b000;
    end

    // State and registered outputs; synchronous reset drops pending pulses.
    always_ff @(posedge CP) begin
        if (!nCLR) begin
            state        <= S_RUN;
            to_cnt       <= '0;
            phase        <= 1'b0;
            bus.sec_en   <= 1'b0;
            bus.min_en   <= 1'b0;
            bus.hour_en  <= 1'b0;
            bus.sec_load <= 1'b0;
            bus.sec_dir  <= 1'b1;
            bus.min_dir  <= 1'b1;
            bus.hour_dir <= 1'b1;
            bus.blink    <= 3'b000;
        end else begin
            state        <= state_nx;
            to_cnt       <= to_nx;
            phase        <= phase_nx;
            bus.sec_en   <= sec_en_nx;
            bus.min_en   <= min_en_nx;
            bus.hour_en  <= hour_en_nx;
            bus.sec_load <= sec_load_nx;
            bus.sec_dir  <= sec_dir_nx;
            bus.min_dir  <= min_dir_nx;
            bus.hour_dir <= hour_dir_nx;
            bus.blink    <= blink_nx;
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the mode controller.
module tb_clock_time_ctrl;

    localparam int TIMEOUT_TICKS = 10;

    logic CP   = 1'b0;
    logic nCLR = 1'b0;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .TO_W         (4)
    ) dut (
        .CP  (CP),
        .nCLR(nCLR),
        .bus (bus)
    );

    always #5 CP = ~CP;

    int errors = 0;
    int checks = 0;

    // Model state: mode number, ticks seen without a button, blink phase,
    // direction bits {hour,min,sec}; expected pulses for the coming edge.
    int       m_mode;
    int       m_idle;
    bit       m_phase;
    bit [2:0] m_dir;
    bit [2:0] e_en;     // {hour,min,sec}
    bit       e_load;
    bit [2:0] e_blink;

    task automatic model_step(input bit r, input bit t, input bit mb, input bit u,
                              input bit d, input logic [7:0] s, input logic [7:0] mn);
        e_en   = 3'b000;
        e_load = 1'b0;
        if (!r) begin
            m_mode  = 0;
            m_idle  = 0;
            m_phase = 1'b0;
            m_dir   = 3'b111;
            e_blink = 3'b000;
            return;
        end
        if (m_mode == 0 && t) begin
            e_en[0] = 1'b1;
            e_en[1] = (s == 8'h59);
            e_en[2] = (s == 8'h59) && (mn == 8'h59);
            m_dir   = 3'b111;
        end
        if (mb) begin
            m_mode  = (m_mode + 1) % 4;
            m_idle  = 0;
            m_phase = 1'b0;
        end else if (m_mode != 0) begin
            if (t) m_phase = !m_phase;
            if (u != d) begin
                if (m_mode == 1) begin e_en[2] = 1'b1; m_dir[2] = u; end
                else if (m_mode == 2) begin e_en[1] = 1'b1; m_dir[1] = u; end
                else e_load = 1'b1;
            end
            if (u || d) m_idle = 0;
            else if (t) begin
                m_idle = m_idle + 1;
                if (m_idle == TIMEOUT_TICKS) begin
                    m_mode  = 0;
                    m_idle  = 0;
                    m_phase = 1'b0;
                end
            end
        end
        e_blink = (m_mode == 0 || !m_phase) ? 3'b000 : 3'(4 >> (m_mode - 1));
    endtask

    // One CP: drive inputs on the falling edge, advance model, sample 1 after rise.
    task automatic cycle(input bit t, input bit mb, input bit u, input bit d,
                         input bit r = 1'b1);
        @(negedge CP);
        nCLR         = r;
        bus.tick     = t;
        bus.mode_btn = mb;
        bus.up_btn   = u;
        bus.dn_btn   = d;
        model_step(r, t, mb, u, d, bus.sec_q, bus.min_q);
        @(posedge CP);
        #1;
    endtask

    task automatic idle2();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (bus.mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", bus.mode); end
        checks++;
        if (bus.blink !== 3'b000) begin errors++; $display("FAIL reset_blink: got %b want 000", bus.blink); end
        checks++;
        if ({bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load});
        end
        checks++;
        if ({bus.hour_dir, bus.min_dir, bus.sec_dir} !== 3'b111) begin
            errors++; $display("FAIL reset_dirs: got %b want 111", {bus.hour_dir, bus.min_dir, bus.sec_dir});
        end
        checks++;
        if (bus.sec_d !== 8'h00) begin errors++; $display("FAIL reset_sec_d: got %h want 00", bus.sec_d); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_run_carry();
        logic [7:0] s_tab [4] = '{8'h59, 8'h58, 8'h59, 8'h5A};
        logic [7:0] m_tab [4] = '{8'h59, 8'h59, 8'h58, 8'h59};
        logic [2:0] e_tab [4] = '{3'b111, 3'b001, 3'b011, 3'b001};
        bus.hour_q = 8'h23;
        for (int i = 0; i < 4; i++) begin
            bus.sec_q = s_tab[i];
            bus.min_q = m_tab[i];
            cycle(1, 0, 0, 0);
            checks++;
            if ({bus.hour_en, bus.min_en, bus.sec_en} !== e_tab[i]) begin
                errors++; $display("FAIL run_carry%0d: en=%b want %b", i, {bus.hour_en, bus.min_en, bus.sec_en}, e_tab[i]);
            end
            checks++;
            if ({bus.hour_dir, bus.min_dir, bus.sec_dir} !== 3'b111) begin
                errors++; $display("FAIL run_dir%0d: got %b want 111", i, {bus.hour_dir, bus.min_dir, bus.sec_dir});
            end
            cycle(0, 0, 0, 0);
            checks++;
            if ({bus.hour_en, bus.min_en, bus.sec_en} !== 3'b000) begin
                errors++; $display("FAIL run_single_pulse%0d: en=%b want 000", i, {bus.hour_en, bus.min_en, bus.sec_en});
            end
            cycle(0, 0, 0, 0);
        end
        bus.sec_q = 8'h10;
        bus.min_q = 8'h20;
        cycle(0, 0, 1, 0);
        checks++;
        if ({bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load} !== 4'b0000) begin
            errors++; $display("FAIL run_ignores_up: got %b want 0000", {bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load});
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_set_walk();
        logic [1:0] exp_mode [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if (bus.mode !== exp_mode[i]) begin
                errors++; $display("FAIL walk%0d: mode=%b want %b", i, bus.mode, exp_mode[i]);
            end
            cycle(0, 0, 0, 0);
        end
    endtask

    task automatic test_set_hour();
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        checks++;
        if ({bus.hour_en, bus.hour_dir, bus.min_en} !== 3'b110) begin
            errors++; $display("FAIL hour_up: {en,dir,min_en}=%b want 110", {bus.hour_en, bus.hour_dir, bus.min_en});
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        checks++;
        if ({bus.hour_en, bus.hour_dir} !== 2'b10) begin
            errors++; $display("FAIL hour_dn: {en,dir}=%b want 10", {bus.hour_en, bus.hour_dir});
        end
        cycle(0, 0, 0, 0);
        checks++;
        if ({bus.hour_en, bus.hour_dir} !== 2'b00) begin
            errors++; $display("FAIL hour_dir_hold: {en,dir}=%b want 00", {bus.hour_en, bus.hour_dir});
        end
        cycle(1, 0, 0, 0);
        checks++;
        if ({bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load, bus.blink} !== 7'b0000_100) begin
            errors++; $display("FAIL hour_tick_frozen: {en,load,blink}=%b want 0000100",
                               {bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load, bus.blink});
        end
        idle2();
        cycle(1, 0, 1, 0);
        checks++;
        if ({bus.hour_en, bus.hour_dir, bus.blink} !== 5'b11_000) begin
            errors++; $display("FAIL hour_tick_up: {en,dir,blink}=%b want 11000", {bus.hour_en, bus.hour_dir, bus.blink});
        end
        idle2();
        cycle(0, 1, 1, 0);
        checks++;
        if ({bus.mode, bus.hour_en, bus.min_en} !== 4'b10_00) begin
            errors++; $display("FAIL collision: {mode,hour_en,min_en}=%b want 1000", {bus.mode, bus.hour_en, bus.min_en});
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_blink();
        logic [2:0] exp_b [3] = '{3'b010, 3'b000, 3'b010};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (bus.blink !== exp_b[i]) begin
                errors++; $display("FAIL blink%0d: got %b want %b", i, bus.blink, exp_b[i]);
            end
            idle2();
        end
        cycle(0, 1, 0, 0);
        checks++;
        if ({bus.mode, bus.blink} !== 5'b11_000) begin
            errors++; $display("FAIL blink_mode_clear: {mode,blink}=%b want 11000", {bus.mode, bus.blink});
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_set_sec();
        cycle(0, 0, 1, 0);
        checks++;
        if ({bus.sec_load, bus.sec_en, bus.sec_d} !== 10'b10_0000_0000) begin
            errors++; $display("FAIL sec_up: load=%b en=%b d=%h want 1 0 00", bus.sec_load, bus.sec_en, bus.sec_d);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (bus.sec_load !== 1'b0) begin errors++; $display("FAIL sec_load_width: got %b want 0", bus.sec_load); end
        cycle(0, 0, 0, 1);
        checks++;
        if ({bus.sec_load, bus.sec_en} !== 2'b10) begin
            errors++; $display("FAIL sec_dn: {load,en}=%b want 10", {bus.sec_load, bus.sec_en});
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 1);
        checks++;
        if ({bus.sec_load, bus.sec_en, bus.min_en, bus.hour_en} !== 4'b0000) begin
            errors++; $display("FAIL sec_updn: got %b want 0000", {bus.sec_load, bus.sec_en, bus.min_en, bus.hour_en});
        end
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        checks++;
        if (bus.mode !== 2'b00) begin errors++; $display("FAIL sec_to_run: mode=%b want 00", bus.mode); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic enter_set_min();
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        enter_set_min();
        for (int i = 1; i <= TIMEOUT_TICKS; i++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (bus.mode !== ((i < TIMEOUT_TICKS) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL timeout_tick%0d: mode=%b", i, bus.mode);
            end
            idle2();
        end
        enter_set_min();
        for (int i = 1; i < TIMEOUT_TICKS - 1; i++) begin
            cycle(1, 0, 0, 0);
            idle2();
        end
        cycle(1, 0, 1, 0);
        checks++;
        if ({bus.mode, bus.min_en} !== 3'b10_1) begin
            errors++; $display("FAIL timeout_restart: {mode,min_en}=%b want 101", {bus.mode, bus.min_en});
        end
        idle2();
        for (int i = 1; i <= TIMEOUT_TICKS; i++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (bus.mode !== ((i < TIMEOUT_TICKS) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL timeout2_tick%0d: mode=%b", i, bus.mode);
            end
            idle2();
        end
    endtask

    task automatic test_reset_mid();
        enter_set_min();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0);
        checks++;
        if ({bus.mode, bus.blink, bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load,
             bus.hour_dir, bus.min_dir, bus.sec_dir} !== 12'b00_000_0000_111) begin
            errors++; $display("FAIL reset_mid: got %b want 000000000111",
                               {bus.mode, bus.blink, bus.hour_en, bus.min_en, bus.sec_en, bus.sec_load,
                                bus.hour_dir, bus.min_dir, bus.sec_dir});
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (bus.mode !== 2'b00) begin errors++; $display("FAIL reset_mid_hold: mode=%b want 00", bus.mode); end
    endtask

    task automatic test_random();
        logic [19:0] got, want;
        for (int it = 0; it < 300; it++) begin
            bit t, mb, u, d, r;
            t = 0; mb = 0; u = 0; d = 0; r = 1;
            case ($urandom_range(0, 3))
                0:       bus.sec_q = 8'h59;
                1:       bus.sec_q = 8'h58;
                2:       bus.sec_q = 8'h5A;
                default: bus.sec_q = 8'($urandom_range(0, 255));
            endcase
            bus.min_q  = ($urandom_range(0, 1) == 0) ? 8'h59 : 8'($urandom_range(0, 255));
            bus.hour_q = 8'($urandom_range(0, 35));
            case ($urandom_range(0, 11))
                0, 1:    t = 1;
                2:       mb = 1;
                3:       u = 1;
                4:       d = 1;
                5:       begin u = 1; d = 1; end
                6:       begin t = 1; u = 1; end
                7:       begin t = 1; d = 1; end
                8:       begin mb = 1; u = 1; end
                9:       begin mb = 1; d = 1; end
                10:      ;
                default: r = 0;
            endcase
            for (int c = 0; c < 3; c++) begin
                if (c == 0) cycle(t, mb, u, d, r);
                else        cycle(0, 0, 0, 0);
                got  = {bus.hour_en, bus.min_en, bus.sec_en, bus.hour_dir, bus.min_dir, bus.sec_dir,
                        bus.sec_load, bus.sec_d, bus.mode, bus.blink};
                want = {e_en, m_dir, e_load, 8'h00, 2'(m_mode), e_blink};
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL random it%0d c%0d: got %b want %b", it, c, got, want);
                end
            end
        end
    endtask

    initial begin
        bus.tick     = 1'b0;
        bus.mode_btn = 1'b0;
        bus.up_btn   = 1'b0;
        bus.dn_btn   = 1'b0;
        bus.sec_q    = 8'h00;
        bus.min_q    = 8'h00;
        bus.hour_q   = 8'h00;
        m_mode  = 0;
        m_idle  = 0;
        m_phase = 1'b0;
        m_dir   = 3'b111;
        e_en    = 3'b000;
        e_load  = 1'b0;
        e_blink = 3'b000;

        test_reset();
        test_run_carry();
        test_set_walk();
        test_set_hour();
        test_blink();
        test_set_sec();
        test_timeout();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
